surf_event_buffer: RTL

Packet-level elastic buffer directly downstream of the per-SURF interface, clocked on sysclk. It consumes the masked 8-bit DOUT event stream, which has no backpressure, and stores whole events in a dual-port RAM. Each event is released to the event builder only after its final byte (tlast) has been written. Events that would overflow the buffer are dropped atomically and counted, so downstream logic never sees a partial event.

---
 rtl/surf_evbuf_pkg.sv | 16 +
 rtl/surf_evbuf_ram.sv | 23 ++
 rtl/surf_event_buffer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/surf_evbuf_pkg.sv
// Shared types for the SURF event buffer: buffer entry, write FSM states, counter width.
package surf_evbuf_pkg;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

endpackage

// File: rtl/surf_evbuf_ram.sv
// Simple dual-port buffer RAM, one write port and one registered read port.
module surf_evbuf_ram
    import surf_evbuf_pkg::*;
#(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  entry_t               i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output entry_t               o_rdata
);

    entry_t r_mem [1 << ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/surf_event_buffer.sv
// Packet elastic buffer: stores whole events, releases them after tlast,
// and drops events atomically when they would overflow.
module surf_event_buffer
    import surf_evbuf_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter     DEBUG     = "FALSE"
) (
    input  logic               sysclk_i,
    input  logic               event_reset_i,
    input  logic [7:0]         s_dout_tdata,
    input  logic               s_dout_tvalid,
    input  logic               s_dout_tlast,
    output logic [7:0]         m_ev_tdata,
    output logic               m_ev_tvalid,
    input  logic               m_ev_tready,
    output logic               m_ev_tlast,
    output logic [CNT_W-1:0]   pkt_count_o,
    output logic [CNT_W-1:0]   drop_count_o,
    output logic               overflow_o,
    output logic [ADDR_BITS:0] level_o
);

    localparam logic [ADDR_BITS:0] DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_BITS:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pf_ptr;
    wr_state_t          r_state;
    logic [CNT_W-1:0]   r_pkt_cnt, r_drop_cnt;
    logic               r_ovf;

    logic   w_full, w_we, w_pop, w_issue;
    logic [1:0] w_busy;
    entry_t w_wdata, w_rdata;
    entry_t r_out, r_skid;
    logic   r_out_v, r_skid_v, r_rd_pend;

    // rd_ptr only advances when downstream takes a byte, so skid contents still occupy space
    assign w_full  = (r_wr_ptr - r_rd_ptr) == DEPTH;
    assign w_we    = (r_state == ACCEPT) && s_dout_tvalid && !w_full && !event_reset_i;
    assign w_wdata = '{last: s_dout_tlast, data: s_dout_tdata};

    always_ff @(posedge sysclk_i) begin
        if (event_reset_i) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_state    <= ACCEPT;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                ACCEPT: if (s_dout_tvalid) begin
                    if (!w_full) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (s_dout_tlast) begin
                            r_cm_ptr  <= r_wr_ptr + PTR_ONE;
                            r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
                        end
                    end else begin
                        r_wr_ptr <= r_cm_ptr;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_ONE;
                        r_ovf <= 1'b1;
                        if (!s_dout_tlast) r_state <= DISCARD;
                    end
                end
                DISCARD: if (s_dout_tvalid && s_dout_tlast) r_state <= ACCEPT;
                default: r_state <= ACCEPT;
            endcase
        end
    end

    // Prefetch only while the landing slot is guaranteed: skid entries plus in-flight read < 2 after pop
    assign w_pop   = r_out_v && m_ev_tready;
    assign w_busy  = {1'b0, r_out_v} + {1'b0, r_skid_v} + {1'b0, r_rd_pend};
    assign w_issue = (r_pf_ptr != r_cm_ptr) && ((w_busy < 2'd2) || ((w_busy == 2'd2) && w_pop));

    always_ff @(posedge sysclk_i) begin
        if (event_reset_i) begin
            r_rd_ptr  <= '0;
            r_pf_ptr  <= '0;
            r_rd_pend <= 1'b0;
            r_out     <= '0;
            r_out_v   <= 1'b0;
            r_skid    <= '0;
            r_skid_v  <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_issue) r_pf_ptr <= r_pf_ptr + PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_pop || !r_out_v) begin
                if (r_skid_v) begin
                    r_out    <= r_skid;
                    r_out_v  <= 1'b1;
                    r_skid_v <= r_rd_pend;
                    if (r_rd_pend) r_skid <= w_rdata;
                end else begin
                    r_out_v <= r_rd_pend;
                    if (r_rd_pend) r_out <= w_rdata;
                end
            end else if (r_rd_pend) begin
                r_skid   <= w_rdata;
                r_skid_v <= 1'b1;
            end
        end
    end

    surf_evbuf_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (sysclk_i),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_BITS-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_issue),
        .i_raddr (r_pf_ptr[ADDR_BITS-1:0]),
        .o_rdata (w_rdata)
    );

    assign m_ev_tdata   = r_out.data;
    assign m_ev_tlast   = r_out.last;
    assign m_ev_tvalid  = r_out_v;
    assign pkt_count_o  = r_pkt_cnt;
    assign drop_count_o = r_drop_cnt;
    assign overflow_o   = r_ovf;
    assign level_o      = r_cm_ptr - r_rd_ptr;

    // Debug taps picked up by the ILA insertion flow
    if (DEBUG == "TRUE") begin : g_dbg
        (* mark_debug = "true" *) logic [ADDR_BITS:0] r_dbg_wr, r_dbg_cm, r_dbg_rd;
        (* mark_debug = "true" *) logic               r_dbg_full, r_dbg_discard;
        always_ff @(posedge sysclk_i) begin
            r_dbg_wr      <= r_wr_ptr;
            r_dbg_cm      <= r_cm_ptr;
            r_dbg_rd      <= r_rd_ptr;
            r_dbg_full    <= w_full;
            r_dbg_discard <= (r_state == DISCARD);
        end
    end

endmodule
